// File: rtl/fetch_ctrl_if.sv
// Bus bundle for fetch_ctrl: instruction-memory request/response and IF/ID delivery.
// master = fetch_ctrl side, slave = memory/pipeline side.
interface fetch_ctrl_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        id_ready;

    modport master (
        output imem_req, imem_addr,
        output if_valid, if_instr, if_pc,
        input  imem_gnt, imem_rvalid, imem_rdata,
        input  redirect_valid, redirect_pc,
        input  id_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        input  if_valid, if_instr, if_pc,
        output imem_gnt, imem_rvalid, imem_rdata,
        output redirect_valid, redirect_pc,
        output id_ready
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: PC, one-outstanding imem requests, output slot + skid.
// Optional FETCH_CTRL_STATS_EN adds stat_fetched / stat_flushed counters.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic         clk,
    input  logic         reset,
    fetch_ctrl_if.master bus
`ifdef FETCH_CTRL_STATS_EN
    ,
    output logic [31:0]  stat_fetched,
    output logic [31:0]  stat_flushed
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DROP
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] issued_pc_q, issued_pc_d;
    logic        slot_valid_q, slot_valid_d;
    logic [31:0] slot_instr_q, slot_instr_d;
    logic [31:0] slot_pc_q, slot_pc_d;
    logic        skid_valid_q, skid_valid_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc_q, skid_pc_d;

    logic        xfer;
    logic        redir;
    logic [31:0] redir_pc;

    assign xfer     = slot_valid_q & bus.id_ready;
    assign redir    = bus.redirect_valid;
    assign redir_pc = bus.redirect_pc & ~32'h3;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            issued_pc_q  <= RESET_PC;
            slot_valid_q <= 1'b0;
            slot_instr_q <= NOP_INSTR;
            slot_pc_q    <= 32'h0;
            skid_valid_q <= 1'b0;
            skid_instr_q <= NOP_INSTR;
            skid_pc_q    <= 32'h0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            issued_pc_q  <= issued_pc_d;
            slot_valid_q <= slot_valid_d;
            slot_instr_q <= slot_instr_d;
            slot_pc_q    <= slot_pc_d;
            skid_valid_q <= skid_valid_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        issued_pc_d  = issued_pc_q;
        slot_valid_d = slot_valid_q;
        slot_instr_d = slot_instr_q;
        slot_pc_d    = slot_pc_q;
        skid_valid_d = skid_valid_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;

        if (xfer) begin
            slot_valid_d = 1'b0;
            slot_instr_d = NOP_INSTR;
        end

        unique case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
                if (redir) pc_d = redir_pc;
            end
            S_REQ: begin
                if (redir) begin
                    pc_d    = redir_pc;
                    // a grant in the redirect cycle still leaves a response to absorb
                    state_d = bus.imem_gnt ? S_DROP : S_REQ;
                end else if (bus.imem_gnt) begin
                    issued_pc_d = pc_q;
                    pc_d        = pc_q + 32'd4;
                    state_d     = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redir) begin
                    pc_d    = redir_pc;
                    state_d = bus.imem_rvalid ? S_REQ : S_DROP;
                end else if (bus.imem_rvalid) begin
                    if (!slot_valid_q || bus.id_ready) begin
                        slot_valid_d = 1'b1;
                        slot_instr_d = bus.imem_rdata;
                        slot_pc_d    = issued_pc_q;
                        state_d      = S_REQ;
                    end else begin
                        skid_valid_d = 1'b1;
                        skid_instr_d = bus.imem_rdata;
                        skid_pc_d    = issued_pc_q;
                        state_d      = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (redir) begin
                    pc_d    = redir_pc;
                    state_d = S_REQ;
                end else if (bus.id_ready) begin
                    slot_valid_d = 1'b1;
                    slot_instr_d = skid_instr_q;
                    slot_pc_d    = skid_pc_q;
                    skid_valid_d = 1'b0;
                    state_d      = S_REQ;
                end
            end
            S_DROP: begin
                if (redir) pc_d = redir_pc;
                if (bus.imem_rvalid) state_d = S_REQ;
            end
            default: state_d = S_IDLE;
        endcase

        if (redir && state_q != S_IDLE) begin
            slot_valid_d = 1'b0;
            slot_instr_d = NOP_INSTR;
            skid_valid_d = 1'b0;
        end
    end

    always_comb begin
        bus.imem_req  = (state_q == S_REQ);
        bus.imem_addr = pc_q;
        bus.if_valid  = slot_valid_q;
        bus.if_instr  = slot_instr_q;
        bus.if_pc     = slot_pc_q;
    end

`ifdef FETCH_CTRL_STATS_EN
    logic [31:0] stat_fetched_q, stat_fetched_d;
    logic [31:0] stat_flushed_q, stat_flushed_d;
    logic        flush_hit;

    // outstanding = waiting on a response, or granted in the redirect cycle
    assign flush_hit = redir && (state_q != S_IDLE) &&
                       (slot_valid_q || skid_valid_q ||
                        (state_q == S_WAIT) ||
                        (state_q == S_REQ && bus.imem_gnt));

    always_comb begin
        stat_fetched_d = stat_fetched_q;
        stat_flushed_d = stat_flushed_q;
        if (xfer)      stat_fetched_d = stat_fetched_q + 32'd1;
        if (flush_hit) stat_flushed_d = stat_flushed_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_fetched_q <= 32'h0;
            stat_flushed_q <= 32'h0;
        end else begin
            stat_fetched_q <= stat_fetched_d;
            stat_flushed_q <= stat_flushed_d;
        end
    end

    assign stat_fetched = stat_fetched_q;
    assign stat_flushed = stat_flushed_q;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: expected requests/deliveries queued by stimulus,
// popped and compared by a negedge monitor. Second instance covers PC wrap.
module tb_fetch_ctrl;

    logic clk;
    logic reset;

    fetch_ctrl_if bus ();
    fetch_ctrl_if w_bus ();

`ifdef FETCH_CTRL_STATS_EN
    logic [31:0] stat_fetched, stat_flushed;
    logic [31:0] w_stat_fetched, w_stat_flushed;
`endif

    fetch_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
`ifdef FETCH_CTRL_STATS_EN
        ,
        .stat_fetched (stat_fetched),
        .stat_flushed (stat_flushed)
`endif
    );

    fetch_ctrl #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk   (clk),
        .reset (reset),
        .bus   (w_bus.master)
`ifdef FETCH_CTRL_STATS_EN
        ,
        .stat_fetched (w_stat_fetched),
        .stat_flushed (w_stat_flushed)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int grant_cnt = 0;

    logic [31:0] addr_q[$];
    logic [31:0] pc_q[$];
    logic [31:0] ins_q[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h4) ? 32'h0010_0093 : (32'h5A00_0000 ^ a);
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%08h required=%08h", name, act, exp);
        end
    endtask

    task automatic fail_evt(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=event required=none", name);
    endtask

    task automatic push_fetch(input logic [31:0] a);
        addr_q.push_back(a);
        pc_q.push_back(a);
        ins_q.push_back(mem_word(a));
    endtask

    // Main memory model: gnt while gnt_en, response lat cycles after gnt.
    logic        gnt_en;
    int          lat;
    logic        pend;
    int          cnt;
    logic [31:0] paddr;

    assign bus.imem_gnt    = bus.imem_req & gnt_en;
    assign bus.imem_rvalid = pend && (cnt == 0);
    assign bus.imem_rdata  = bus.imem_rvalid ? mem_word(paddr) : 32'hDEAD_BEEF;

    always @(posedge clk) begin
        if (reset) begin
            pend <= 1'b0;
            cnt  <= 0;
        end else if (bus.imem_req && bus.imem_gnt) begin
            pend  <= 1'b1;
            cnt   <= lat - 1;
            paddr <= bus.imem_addr;
        end else if (pend) begin
            if (cnt == 0) pend <= 1'b0;
            else          cnt  <= cnt - 1;
        end
    end

    // Wrap instance memory: always grants, responds next cycle.
    logic        w_rv;
    logic [31:0] w_pa;

    assign w_bus.imem_gnt       = w_bus.imem_req;
    assign w_bus.imem_rvalid    = w_rv;
    assign w_bus.imem_rdata     = mem_word(w_pa);
    assign w_bus.redirect_valid = 1'b0;
    assign w_bus.redirect_pc    = 32'h0;
    assign w_bus.id_ready       = 1'b1;

    always @(posedge clk) begin
        if (reset) w_rv <= 1'b0;
        else       w_rv <= w_bus.imem_req;
        w_pa <= w_bus.imem_addr;
    end

    logic [31:0] w_addrs[$];
    logic [31:0] w_pcs[$];
    logic [31:0] w_ins[$];

    always @(negedge clk) begin
        if (!reset) begin
            if (w_bus.imem_req && w_addrs.size() < 2)
                w_addrs.push_back(w_bus.imem_addr);
            if (w_bus.if_valid && w_pcs.size() < 2) begin
                w_pcs.push_back(w_bus.if_pc);
                w_ins.push_back(w_bus.if_instr);
            end
        end
    end

    // Monitor
    logic        prev_stall = 1'b0;
    logic [31:0] prev_pc, prev_ins;

    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (bus.imem_req && bus.imem_gnt) begin
                grant_cnt++;
                if (addr_q.size() == 0) fail_evt("unexpected_req");
                else chk("req_addr", bus.imem_addr, addr_q.pop_front());
            end
            chk("req_outstanding", 32'(bus.imem_req & pend), 32'h0);
            if (bus.if_valid && bus.id_ready) begin
                if (pc_q.size() == 0) begin
                    fail_evt("unexpected_instr");
                end else begin
                    chk("if_pc", bus.if_pc, pc_q.pop_front());
                    chk("if_instr", bus.if_instr, ins_q.pop_front());
                end
            end
            if (!bus.if_valid) chk("nop_idle", bus.if_instr, 32'h0000_0013);
            if (prev_stall && bus.if_valid) begin
                chk("stable_pc", bus.if_pc, prev_pc);
                chk("stable_instr", bus.if_instr, prev_ins);
            end
            prev_stall = bus.if_valid && !bus.id_ready;
            prev_pc    = bus.if_pc;
            prev_ins   = bus.if_instr;
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        bus.redirect_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req", 32'(bus.imem_req), 32'h0);
        chk("rst_addr", bus.imem_addr, 32'h0);
        chk("rst_valid", 32'(bus.if_valid), 32'h0);
        chk("rst_instr", bus.if_instr, 32'h0000_0013);
        chk("rst_pc", bus.if_pc, 32'h0);
        chk("rst_wrap_addr", w_bus.imem_addr, 32'hFFFF_FFFC);
`ifdef FETCH_CTRL_STATS_EN
        chk("rst_stat_fetched", stat_fetched, 32'h0);
        chk("rst_stat_flushed", stat_flushed, 32'h0);
`endif
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic wait_grants(input int n, input bit stop);
        for (int i = 0; i < 200; i++) begin
            if (grant_cnt >= n) break;
            @(posedge clk);
        end
        if (grant_cnt < n) fail_evt("grant_timeout");
        #1;
        if (stop) gnt_en = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100; i++) begin
            if (pc_q.size() == 0) break;
            @(posedge clk);
        end
        if (pc_q.size() != 0) fail_evt("drain_timeout");
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    int base;

    initial begin
        reset              = 1'b1;
        gnt_en             = 1'b1;
        lat                = 1;
        bus.id_ready       = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;

        // Streaming fetch, 1-cycle memory, first valid 3 cycles after release
        base = grant_cnt;
        for (int i = 0; i < 4; i++) push_fetch(32'(i * 4));
        do_reset();
        @(posedge clk);
        @(posedge clk);
        #1 chk("first_valid_early", 32'(bus.if_valid), 32'h0);
        @(posedge clk);
        #1 chk("first_valid", 32'(bus.if_valid), 32'h1);
        chk("first_pc", bus.if_pc, 32'h0);
        wait_grants(base + 4, 1'b1);
        drain();

        // Backpressure: slot holds pc 0, skid pc 4, no request while holding
        gnt_en       = 1'b1;
        bus.id_ready = 1'b0;
        base = grant_cnt;
        push_fetch(32'h0);
        push_fetch(32'h4);
        do_reset();
        wait_grants(base + 2, 1'b0);
        repeat (6) begin
            @(negedge clk);
            chk("hold_no_req", 32'(bus.imem_req), 32'h0);
        end
        chk("hold_slot_pc", bus.if_pc, 32'h0);
        @(posedge clk);
        #1;
        gnt_en       = 1'b0;
        bus.id_ready = 1'b1;
        drain();

        // Redirect while WAIT with a late response -> DROP, next address 0x20
        gnt_en = 1'b1;
        lat    = 3;
        base = grant_cnt;
        addr_q.push_back(32'h0);
        do_reset();
        wait_grants(base + 1, 1'b0);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h23;
        push_fetch(32'h20);
        @(posedge clk);
        #1 bus.redirect_valid = 1'b0;
        chk("redir_wait_valid", 32'(bus.if_valid), 32'h0);
        wait_grants(base + 2, 1'b1);
        drain();

        // Redirect in the same cycle as rvalid -> data discarded
        gnt_en = 1'b1;
        lat    = 2;
        base = grant_cnt;
        addr_q.push_back(32'h0);
        do_reset();
        wait_grants(base + 1, 1'b0);
        @(posedge clk);
        #1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h40;
        push_fetch(32'h40);
        @(posedge clk);
        #1 bus.redirect_valid = 1'b0;
        chk("redir_rv_valid", 32'(bus.if_valid), 32'h0);
        chk("redir_rv_req", 32'(bus.imem_req), 32'h1);
        chk("redir_rv_addr", bus.imem_addr, 32'h40);
        wait_grants(base + 2, 1'b1);
        drain();

`ifdef FETCH_CTRL_STATS_EN
        // 10 transfers then two flushing redirects
        gnt_en = 1'b1;
        lat    = 1;
        base = grant_cnt;
        for (int i = 0; i < 10; i++) push_fetch(32'(i * 4));
        do_reset();
        wait_grants(base + 10, 1'b1);
        drain();
        addr_q.push_back(32'h28);
        gnt_en = 1'b1;
        wait_grants(base + 11, 1'b0);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h100;
        addr_q.push_back(32'h100);
        @(posedge clk);
        #1 bus.redirect_valid = 1'b0;
        wait_grants(base + 12, 1'b0);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h200;
        gnt_en             = 1'b0;
        @(posedge clk);
        #1 bus.redirect_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("stat_fetched", stat_fetched, 32'd10);
        chk("stat_flushed", stat_flushed, 32'd2);
        do_reset();
`endif

        // PC wrap on the RESET_PC=FFFFFFFC instance
        chk("wrap_addr0", (w_addrs.size() > 0) ? w_addrs[0] : 32'hDEAD_DEAD,
            32'hFFFF_FFFC);
        chk("wrap_addr1", (w_addrs.size() > 1) ? w_addrs[1] : 32'hDEAD_DEAD,
            32'h0000_0000);
        chk("wrap_pc0", (w_pcs.size() > 0) ? w_pcs[0] : 32'hDEAD_DEAD,
            32'hFFFF_FFFC);
        chk("wrap_ins0", (w_ins.size() > 0) ? w_ins[0] : 32'hDEAD_DEAD,
            32'hA5FF_FFFC);
        chk("wrap_pc1", (w_pcs.size() > 1) ? w_pcs[1] : 32'hDEAD_DEAD,
            32'h0000_0000);

        chk("addr_q_empty", 32'(addr_q.size()), 32'h0);
        chk("data_q_empty", 32'(pc_q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
